// File: rtl/hex_word_scroller.sv
// Six-slot 3-bit character message for the DE10 HEX displays, rotated either by a
// free-running prescaler tick (RUN) or by rising edges of a manual step input (HOLD).
module hex_word_scroller #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter logic [2:0]  BLANK    = 3'b111
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        load_valid,
  input  logic [17:0] load_data,
  output logic        load_ready,
  input  logic        enable,
  input  logic        dir,
  input  logic        step,
  output logic [17:0] char_out,
  output logic [2:0]  position,
  output logic        wrap
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_e;

  state_e        state_q, state_d;
  logic [17:0]   char_q, char_d;
  logic [2:0]    pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap_q, wrap_d;
  logic          ready_q, ready_d;
  logic          step_q;
  logic          accept, step_edge, rotate;

  assign accept    = load_valid & ready_q;
  assign step_edge = step & ~step_q;

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    rotate  = 1'b0;

    // A load outranks everything else, including a tick on the same cycle.
    if (accept) begin
      state_d = LOAD;
      char_d  = load_data;
      pos_d   = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          pos_d   = '0;
          presc_d = '0;
          state_d = enable ? RUN : HOLD;
        end
        RUN: begin
          if (!enable) begin
            state_d = HOLD;
          end else if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            rotate  = 1'b1;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        HOLD: begin
          if (enable) state_d = RUN;
          else if (step_edge) rotate = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (rotate) begin
      if (!dir) begin
        char_d = {char_q[14:0], char_q[17:15]};
        pos_d  = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
      end else begin
        char_d = {char_q[2:0], char_q[17:3]};
        pos_d  = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
      end
      wrap_d = (pos_d == 3'd0);
    end

    ready_d = (state_d != LOAD);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      char_q  <= {6{BLANK}};
      pos_q   <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      ready_q <= 1'b1;
      step_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      ready_q <= ready_d;
      step_q  <= step;
    end
  end

  assign char_out   = char_q;
  assign position   = pos_q;
  assign wrap       = wrap_q;
  assign load_ready = ready_q;

endmodule
